// File: rtl/maxnet_mem_loader.sv
// Write-side loader for the Maxnet datapath: fills the W and X banks from a word stream,
// pulses start_o, then holds both banks stable until the datapath reports it has finished.
module maxnet_mem_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NX     = 4,
    parameter int unsigned NW     = NX * NX
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    input  logic                   in_last_i,
    input  logic                   reload_w_i,
    input  logic                   engine_done_i,
    output logic [NX*DATA_W-1:0]   x_o,
    output logic [NW*DATA_W-1:0]   w_o,
    output logic                   start_o,
    output logic                   busy_o,
    output logic                   frame_err_o
);

    localparam int unsigned IdxW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned XIdxW = (NX > 1) ? $clog2(NX) : 1;
    localparam logic [IdxW-1:0] WLast = IdxW'(NW - 1);
    localparam logic [IdxW-1:0] XLast = IdxW'(NX - 1);

    typedef enum logic [1:0] {StLoadW, StLoadX, StStart, StRun} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                err_q, err_d;
    logic                first_q, first_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   w_q [NW];
    logic [DATA_W-1:0]   x_q [NX];
    logic                accept;
    logic                w_we, x_we;

    assign accept = in_valid_i && in_ready_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StLoadW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        first_d = 1'b0;
        w_we    = 1'b0;
        x_we    = 1'b0;
        unique case (state_q)
            StLoadW: begin
                if (accept) begin
                    w_we = 1'b1;
                    if (idx_q == WLast) begin
                        idx_d   = '0;
                        state_d = StLoadX;
                        if (!in_last_i) err_d = 1'b1;
                    end else if (in_last_i) begin
                        // Premature end of block: restart the W phase.
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StLoadX: begin
                if (accept) begin
                    x_we = 1'b1;
                    if (idx_q == XLast) begin
                        idx_d   = '0;
                        state_d = StStart;
                        if (!in_last_i) err_d = 1'b1;
                    end else if (in_last_i) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStart: begin
                state_d = StRun;
                first_d = 1'b1;
            end
            StRun: begin
                // is_finished is stale on the first RUN cycle, so it is not trusted there.
                if (engine_done_i && !first_q) begin
                    idx_d   = '0;
                    state_d = reload_w_i ? StLoadW : StLoadX;
                end
            end
            default: begin
                state_d = StLoadW;
                idx_d   = '0;
            end
        endcase
        in_ready_d = (state_d == StLoadW) || (state_d == StLoadX);
    end

    // Output decode
    always_comb begin
        start_o = (state_q == StStart);
        busy_o  = (state_q == StStart) || (state_q == StRun);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            err_q      <= err_d;
            first_q    <= first_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NW); k++) w_q[k] <= '0;
        end else if (w_we) begin
            w_q[idx_q] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NX); k++) x_q[k] <= '0;
        end else if (x_we) begin
            x_q[idx_q[XIdxW-1:0]] <= in_data_i;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(NW); k++) w_o[k*DATA_W +: DATA_W] = w_q[k];
        for (int k = 0; k < int'(NX); k++) x_o[k*DATA_W +: DATA_W] = x_q[k];
    end

    assign in_ready_o  = in_ready_q;
    assign frame_err_o = err_q;

endmodule
